// File: rtl/seg7_digit_scanner.sv
// Two-digit scanner for the 7-segment PMOD. It latches a byte over valid/ready and
// alternates its nibbles onto one digit bus, with a blanking gap around each select change.
module seg7_digit_scanner #(
    parameter int REFRESH_DIV  = 12000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value_in,
    input  logic       value_valid,
    output logic       value_ready,
    input  logic       lz_suppress,
    output logic [3:0] digit_out,
    output logic       digit_sel,
    output logic       digit_blank
);

    localparam int MAX_LIM = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LIM);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        BLANK_HL = 2'd0,
        SHOW_LO  = 2'd1,
        BLANK_LH = 2'd2,
        SHOW_HI  = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       shadow_r;
    logic             digit_sel_r;
    logic             digit_blank_r;
    logic             value_ready_r;

    // Scan FSM: dwell counter, shadow capture and registered select/blank/ready outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= BLANK_HL;
            cnt_r         <= {CNT_W{1'b0}};
            shadow_r      <= 8'h00;
            digit_sel_r   <= 1'b0;
            digit_blank_r <= 1'b1;
            value_ready_r <= 1'b1;
        end else begin
            // Ready is only high in BLANK_HL, so the shadow is frozen for the rest of the frame.
            if (value_valid && value_ready_r) begin
                shadow_r <= value_in;
            end else begin
                shadow_r <= shadow_r;
            end
            case (state_r)
                BLANK_HL: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_r       <= SHOW_LO;
                        cnt_r         <= {CNT_W{1'b0}};
                        digit_sel_r   <= 1'b0;
                        digit_blank_r <= 1'b0;
                        value_ready_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                SHOW_LO: begin
                    if (cnt_r == SHOW_LAST) begin
                        state_r       <= BLANK_LH;
                        cnt_r         <= {CNT_W{1'b0}};
                        digit_sel_r   <= 1'b1;
                        digit_blank_r <= 1'b1;
                        value_ready_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                BLANK_LH: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_r       <= SHOW_HI;
                        cnt_r         <= {CNT_W{1'b0}};
                        digit_sel_r   <= 1'b1;
                        // Leading-zero decision is taken once on entry and held for the interval.
                        digit_blank_r <= lz_suppress && (shadow_r[7:4] == 4'h0);
                        value_ready_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                SHOW_HI: begin
                    if (cnt_r == SHOW_LAST) begin
                        state_r       <= BLANK_HL;
                        cnt_r         <= {CNT_W{1'b0}};
                        digit_sel_r   <= 1'b0;
                        digit_blank_r <= 1'b1;
                        value_ready_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r       <= BLANK_HL;
                    cnt_r         <= {CNT_W{1'b0}};
                    digit_sel_r   <= 1'b0;
                    digit_blank_r <= 1'b1;
                    value_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign value_ready = value_ready_r;
    assign digit_sel   = digit_sel_r;
    assign digit_blank = digit_blank_r;
    assign digit_out   = digit_sel_r ? shadow_r[7:4] : shadow_r[3:0];

endmodule

// File: doc/seg7_digit_scanner.md
Name: seg7_digit_scanner

Overview:
- Upstream stage of the 7-segment decoder on the dual-digit PMOD.
- Accepts an 8-bit value through a valid/ready handshake and holds it in a shadow register.
- Time-multiplexes the two nibbles onto one 4-bit digit bus, which the decoder consumes.
- Drives the digit-select line, with a blanking gap around every select change to suppress ghosting, plus optional leading-zero suppression.

Parameters:
- REFRESH_DIV, 12000: clocks each digit is shown (1 ms at 12 MHz). Legal range ≥ 2.
- BLANK_CYCLES, 64: clocks of blanking between digits. Legal range ≥ 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- value_in  in  8  value to display; [7:4] = left/tens digit, [3:0] = right/ones digit
- value_valid  in  1  producer has value_in available
- value_ready  out  1  block accepts value_in this cycle
- lz_suppress  in  1  1 = blank the left digit when shadow[7:4] == 0
- digit_out  out  4  nibble to the segment decoder
- digit_sel  out  1  0 = right digit active, 1 = left digit active (drives the PMOD select pin)
- digit_blank  out  1  1 = segments must be off

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- FSM states: BLANK_HL, SHOW_LO, BLANK_LH, SHOW_HI.
- Counter width: $clog2(max(REFRESH_DIV, BLANK_CYCLES)).
- Transitions:
  - BLANK_HL → SHOW_LO after BLANK_CYCLES clocks.
  - SHOW_LO → BLANK_LH after REFRESH_DIV clocks.
  - BLANK_LH → SHOW_HI after BLANK_CYCLES clocks.
  - SHOW_HI → BLANK_HL after REFRESH_DIV clocks.
  - Counter clears on every state entry.
- Frame period: 2*(REFRESH_DIV + BLANK_CYCLES) clocks.
- Reset (any cycle, mid-operation included) takes effect on the next edge:
  - state = BLANK_HL, counter = 0, shadow = 8'h00
  - digit_sel = 0, digit_blank = 1, value_ready = 1
  - digit_out = 0
- digit_sel and digit_blank are registered and update on the edge that enters a state:
  - BLANK_HL: sel = 0, blank = 1
  - SHOW_LO: sel = 0, blank = 0
  - BLANK_LH: sel = 1, blank = 1
  - SHOW_HI: sel = 1, blank = lz_suppress && (shadow[7:4] == 0)
- digit_out = digit_sel ? shadow[7:4] : shadow[3:0], driven combinationally from registers only. It is stable before unblank because select always changes while blank = 1.
- lz_suppress is sampled on the edge entering SHOW_HI. It is held for the whole SHOW_HI interval.
- Handshake:
  - value_ready = 1 exactly while state == BLANK_HL, and is registered.
  - Transfer occurs when value_valid && value_ready at an edge; shadow <= value_in on that edge.
  - Multiple transfers within one BLANK_HL window: the last one wins.
  - valid without ready: no effect, no stall, value not captured.
  - The shadow never changes during SHOW_LO, BLANK_LH or SHOW_HI, so frames are tear-free.
- Latency: a value accepted in BLANK_HL is visible on the first SHOW_LO cycle after that window closes. Worst-case wait for ready is 2*REFRESH_DIV + BLANK_CYCLES clocks.
- Counter wrap: none. The counter compares against limit-1 and clears; there is no free-running overflow.
- value_in is not modified (no BCD conversion); nibbles A–F pass through to the decoder unchanged.

Test Plan (REFRESH_DIV = 10, BLANK_CYCLES = 2 unless stated):
1. Reset, then idle, no valid → cycles 1–2 after rst low: blank = 1, sel = 0, ready = 1. Then 10 cycles blank = 0, sel = 0, digit_out = 0. Then 2 blank / sel = 1. Then 10 show. Period = 24 clocks, repeating.
2. value_in = 8'h47 with valid held high from reset → captured in first BLANK_HL. SHOW_LO shows digit_out = 7 with sel = 0; SHOW_HI shows digit_out = 4 with sel = 1. ready is low in all other states.
3. Assert valid with 8'h95 for one cycle during SHOW_LO → not captured, display unchanged. Hold it until ready → captured, and 9/5 appear in the next frame.
4. Two transfers in one BLANK_HL window (8'h12, then 8'h34 next cycle) → display shows 4/3, never 2/1 in SHOW states.
5. Shadow = 8'h05, lz_suppress = 1 → SHOW_HI keeps blank = 1 with sel = 1. With lz_suppress = 0 → SHOW_HI blank = 0, digit_out = 0. Shadow = 8'h50 with lz = 1 → left digit shown (5).
6. Assert rst for one cycle in the middle of SHOW_HI with shadow = 8'hAB → next edge: shadow = 0, sel = 0, blank = 1, ready = 1, counter restarts. The 24-clock sequence repeats exactly as in scenario 1. Also check every sel change coincides with blank = 1.
